// File: rtl/gpu_raster_pkg.sv
// rtl/gpu_raster_pkg.sv - shared raster command encoding, FSM states and framebuffer defaults
package common;

    typedef enum logic [1:0] {
        RASTER_CMD_FILL  = 2'd0,
        RASTER_CMD_POINT = 2'd1,
        RASTER_CMD_LINE  = 2'd2,
        RASTER_CMD_RECT  = 2'd3
    } raster_command_t;

endpackage

package gpu_common;

    localparam int FB_WIDTH_DEFAULT  = 214;
    localparam int FB_HEIGHT_DEFAULT = 160;

    typedef enum logic [2:0] {
        RS_IDLE  = 3'd0,
        RS_POINT = 3'd1,
        RS_LINE  = 3'd2,
        RS_RECT  = 3'd3,
        RS_FILL  = 3'd4
    } raster_state_t;

    function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/gpu_raster_if.sv
// rtl/gpu_raster_if.sv - command input and framebuffer write bundle for gpu_raster
interface gpu_raster_if;
    import common::*;

    raster_command_t gpu_command;
    logic [7:0]      gpu_x0;
    logic [7:0]      gpu_y0;
    logic [7:0]      gpu_x1;
    logic [7:0]      gpu_y1;
    logic [2:0]      gpu_colour;
    logic            gpu_execute_request;
    logic            gpu_busy;
    logic [7:0]      fb_x;
    logic [7:0]      fb_y;
    logic [2:0]      fb_colour;
    logic            fb_write_en;

    modport master (
        output gpu_command, gpu_x0, gpu_y0, gpu_x1, gpu_y1, gpu_colour, gpu_execute_request,
        input  gpu_busy, fb_x, fb_y, fb_colour, fb_write_en
    );

    modport slave (
        input  gpu_command, gpu_x0, gpu_y0, gpu_x1, gpu_y1, gpu_colour, gpu_execute_request,
        output gpu_busy, fb_x, fb_y, fb_colour, fb_write_en
    );

endinterface

// File: rtl/gpu_raster_line_stepper.sv
// rtl/gpu_raster_line_stepper.sv - integer Bresenham datapath, one step per cycle
module line_stepper
    import gpu_common::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       step,
    input  logic [7:0] x0,
    input  logic [7:0] y0,
    input  logic [7:0] x1,
    input  logic [7:0] y1,
    output logic [7:0] x,
    output logic [7:0] y,
    output logic [7:0] next_x,
    output logic [7:0] next_y,
    output logic       done
);

    logic [7:0]        x_end;
    logic [7:0]        y_end;
    logic              x_neg;
    logic              y_neg;
    logic signed [10:0] dx;
    logic signed [10:0] dy;
    logic signed [10:0] err;
    logic signed [10:0] e2;
    logic signed [10:0] err_next;
    logic signed [10:0] dx_in;
    logic signed [10:0] dy_in;
    logic              step_x;
    logic              step_y;

    always_comb begin
        dx_in = $signed({3'b000, abs_diff(x0, x1)});
        dy_in = -$signed({3'b000, abs_diff(y0, y1)});
    end

    // next_x/next_y are the look-ahead pixel so the top can register it in the same edge as the step
    always_comb begin
        e2       = err <<< 1;
        step_x   = (e2 >= dy);
        step_y   = (e2 <= dx);
        err_next = err;
        next_x   = x;
        next_y   = y;
        if (step_x) begin
            err_next = err_next + dy;
            next_x   = x_neg ? (x - 8'd1) : (x + 8'd1);
        end
        if (step_y) begin
            err_next = err_next + dx;
            next_y   = y_neg ? (y - 8'd1) : (y + 8'd1);
        end
    end

    assign done = (x == x_end) && (y == y_end);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x     <= 8'd0;
            y     <= 8'd0;
            x_end <= 8'd0;
            y_end <= 8'd0;
            x_neg <= 1'b0;
            y_neg <= 1'b0;
            dx    <= 11'sd0;
            dy    <= 11'sd0;
            err   <= 11'sd0;
        end else if (load) begin
            x     <= x0;
            y     <= y0;
            x_end <= x1;
            y_end <= y1;
            x_neg <= (x1 < x0);
            y_neg <= (y1 < y0);
            dx    <= dx_in;
            dy    <= dy_in;
            err   <= dx_in + dy_in;
        end else if (step) begin
            x     <= next_x;
            y     <= next_y;
            err   <= err_next;
        end
    end

endmodule

// File: rtl/gpu_raster.sv
// rtl/gpu_raster.sv - raster command FSM expanding FILL/POINT/LINE/RECT into per-cycle pixel writes
module gpu_raster
    import common::*;
    import gpu_common::*;
#(
    parameter int FB_WIDTH  = FB_WIDTH_DEFAULT,
    parameter int FB_HEIGHT = FB_HEIGHT_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    gpu_raster_if.slave  bus
);

    localparam logic [8:0] WIDTH_LIM  = 9'(FB_WIDTH);
    localparam logic [8:0] HEIGHT_LIM = 9'(FB_HEIGHT);
    localparam logic [7:0] X_LAST     = 8'(FB_WIDTH - 1);
    localparam logic [7:0] Y_LAST     = 8'(FB_HEIGHT - 1);

    raster_state_t state;
    raster_state_t state_n;

    logic [7:0] x_lo;
    logic [7:0] x_hi;
    logic [7:0] y_lo;
    logic [7:0] y_hi;
    logic [7:0] nx;
    logic [7:0] ny;
    logic       we_n;
    logic       latch;
    logic       line_load;
    logic       line_step;
    logic [7:0] line_x;
    logic [7:0] line_y;
    logic [7:0] line_nx;
    logic [7:0] line_ny;
    logic       line_done;
    logic       row_end;
    logic       last_pix;
    logic [7:0] req_xmin;
    logic [7:0] req_xmax;
    logic [7:0] req_ymin;
    logic [7:0] req_ymax;

    function automatic logic visible(input logic [7:0] px, input logic [7:0] py);
        return ({1'b0, px} < WIDTH_LIM) && ({1'b0, py} < HEIGHT_LIM);
    endfunction

    assign req_xmin = (bus.gpu_x0 < bus.gpu_x1) ? bus.gpu_x0 : bus.gpu_x1;
    assign req_xmax = (bus.gpu_x0 < bus.gpu_x1) ? bus.gpu_x1 : bus.gpu_x0;
    assign req_ymin = (bus.gpu_y0 < bus.gpu_y1) ? bus.gpu_y0 : bus.gpu_y1;
    assign req_ymax = (bus.gpu_y0 < bus.gpu_y1) ? bus.gpu_y1 : bus.gpu_y0;

    // fb_x/fb_y double as the RECT/FILL scan counters
    assign row_end  = (bus.fb_x == x_hi);
    assign last_pix = row_end && (bus.fb_y == y_hi);
    assign bus.gpu_busy = (state != RS_IDLE);

    line_stepper u_line (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (line_load),
        .step   (line_step),
        .x0     (bus.gpu_x0),
        .y0     (bus.gpu_y0),
        .x1     (bus.gpu_x1),
        .y1     (bus.gpu_y1),
        .x      (line_x),
        .y      (line_y),
        .next_x (line_nx),
        .next_y (line_ny),
        .done   (line_done)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RS_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        nx        = bus.fb_x;
        ny        = bus.fb_y;
        we_n      = 1'b0;
        latch     = 1'b0;
        line_load = 1'b0;
        line_step = 1'b0;
        case (state)
            RS_IDLE: begin
                if (bus.gpu_execute_request) begin
                    latch = 1'b1;
                    case (bus.gpu_command)
                        RASTER_CMD_POINT: begin
                            state_n = RS_POINT;
                            nx      = bus.gpu_x0;
                            ny      = bus.gpu_y0;
                        end
                        RASTER_CMD_LINE: begin
                            state_n   = RS_LINE;
                            line_load = 1'b1;
                            nx        = bus.gpu_x0;
                            ny        = bus.gpu_y0;
                        end
                        RASTER_CMD_RECT: begin
                            state_n = RS_RECT;
                            nx      = req_xmin;
                            ny      = req_ymin;
                        end
                        RASTER_CMD_FILL: begin
                            state_n = RS_FILL;
                            nx      = 8'd0;
                            ny      = 8'd0;
                        end
                    endcase
                    we_n = visible(nx, ny);
                end
            end
            RS_POINT: begin
                state_n = RS_IDLE;
            end
            RS_LINE: begin
                if (line_done) begin
                    state_n = RS_IDLE;
                end else begin
                    line_step = 1'b1;
                    nx        = line_nx;
                    ny        = line_ny;
                    we_n      = visible(nx, ny);
                end
            end
            RS_RECT, RS_FILL: begin
                if (last_pix) begin
                    state_n = RS_IDLE;
                end else begin
                    if (row_end) begin
                        nx = x_lo;
                        ny = bus.fb_y + 8'd1;
                    end else begin
                        nx = bus.fb_x + 8'd1;
                    end
                    we_n = visible(nx, ny);
                end
            end
            default: begin
                state_n = RS_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.fb_x        <= 8'd0;
            bus.fb_y        <= 8'd0;
            bus.fb_colour   <= 3'd0;
            bus.fb_write_en <= 1'b0;
            x_lo            <= 8'd0;
            x_hi            <= 8'd0;
            y_lo            <= 8'd0;
            y_hi            <= 8'd0;
        end else begin
            bus.fb_x        <= nx;
            bus.fb_y        <= ny;
            bus.fb_write_en <= we_n;
            if (latch) begin
                bus.fb_colour <= bus.gpu_colour;
                case (bus.gpu_command)
                    RASTER_CMD_RECT: begin
                        x_lo <= req_xmin;
                        x_hi <= req_xmax;
                        y_lo <= req_ymin;
                        y_hi <= req_ymax;
                    end
                    RASTER_CMD_FILL: begin
                        x_lo <= 8'd0;
                        x_hi <= X_LAST;
                        y_lo <= 8'd0;
                        y_hi <= Y_LAST;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // the stepper's current pixel must always be the one on the output registers
    always @(posedge clk) begin
        if (rst_n && state == RS_LINE) begin
            assert (line_x == bus.fb_x && line_y == bus.fb_y);
        end
    end

endmodule

// File: tb/tb_gpu_raster.sv
// tb/tb_gpu_raster.sv - directed self-checking bench for gpu_raster
module tb_gpu_raster;
    import common::*;

    logic clk = 1'b0;
    logic rst_n;

    always #10 clk = ~clk;

    gpu_raster_if bus();

    gpu_raster #(.FB_WIDTH(214), .FB_HEIGHT(160)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
        logic       we;
    } pix_t;

    pix_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic push_pix(input int x, input int y);
        pix_t p;
        p.x  = 8'(x);
        p.y  = 8'(y);
        p.we = (x < 214) && (y < 160);
        exp_q.push_back(p);
    endtask

    task automatic issue(input raster_command_t cmd, input int x0, input int y0,
                         input int x1, input int y1, input int col);
        @(negedge clk);
        bus.gpu_command         = cmd;
        bus.gpu_x0              = 8'(x0);
        bus.gpu_y0              = 8'(y0);
        bus.gpu_x1              = 8'(x1);
        bus.gpu_y1              = 8'(y1);
        bus.gpu_colour          = 3'(col);
        bus.gpu_execute_request = 1'b1;
        @(negedge clk);
        bus.gpu_execute_request = 1'b0;
    endtask

    // Called in cycle 1; walks the busy window comparing each presented pixel with exp_q.
    task automatic run_expect(input string tag, input int col, input int pulse_at);
        int  n          = 0;
        int  writes     = 0;
        int  exp_writes = 0;
        int  first_bad  = -1;
        logic bad;
        foreach (exp_q[i]) if (exp_q[i].we) exp_writes++;
        if (pulse_at >= 0) begin
            bus.gpu_command = RASTER_CMD_POINT;
            bus.gpu_x0      = 8'd0;
            bus.gpu_y0      = 8'd0;
            bus.gpu_colour  = 3'd1;
        end
        while (n < exp_q.size() + 8) begin
            if (bus.gpu_busy !== 1'b1) break;
            if (n < exp_q.size()) begin
                bad = (bus.fb_write_en !== exp_q[n].we) ||
                      (exp_q[n].we && (bus.fb_x !== exp_q[n].x || bus.fb_y !== exp_q[n].y ||
                                       bus.fb_colour !== 3'(col)));
                if (bad && first_bad < 0) first_bad = n;
            end
            if (bus.fb_write_en === 1'b1) writes++;
            bus.gpu_execute_request = (n == pulse_at);
            n++;
            @(negedge clk);
        end
        bus.gpu_execute_request = 1'b0;
        check({tag, " busy_cycles"}, n, exp_q.size());
        check({tag, " first_bad_pixel"}, first_bad, -1);
        check({tag, " writes"}, writes, exp_writes);
        check({tag, " write_en_after"}, int'(bus.fb_write_en), 0);
        exp_q.delete();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n                   = 1'b0;
        bus.gpu_command         = RASTER_CMD_FILL;
        bus.gpu_x0              = 8'd0;
        bus.gpu_y0              = 8'd0;
        bus.gpu_x1              = 8'd0;
        bus.gpu_y1              = 8'd0;
        bus.gpu_colour          = 3'd0;
        bus.gpu_execute_request = 1'b0;
        repeat (3) @(negedge clk);
        check("reset busy", int'(bus.gpu_busy), 0);
        check("reset write_en", int'(bus.fb_write_en), 0);
        check("reset fb_x", int'(bus.fb_x), 0);
        check("reset fb_y", int'(bus.fb_y), 0);
        check("reset colour", int'(bus.fb_colour), 0);
        rst_n = 1'b1;

        push_pix(100, 100);
        issue(RASTER_CMD_POINT, 100, 100, 0, 0, 6);
        run_expect("point", 6, -1);

        for (int i = 10; i <= 100; i++) push_pix(i, i);
        issue(RASTER_CMD_LINE, 10, 10, 100, 100, 6);
        run_expect("line_up", 6, -1);

        for (int i = 100; i >= 10; i--) push_pix(i, i);
        issue(RASTER_CMD_LINE, 100, 100, 10, 10, 6);
        run_expect("line_down", 6, -1);

        for (int y = 90; y <= 130; y++)
            for (int x = 10; x <= 204; x++) push_pix(x, y);
        issue(RASTER_CMD_RECT, 204, 130, 10, 90, 3);
        run_expect("rect_swapped", 3, -1);

        for (int y = 0; y < 160; y++)
            for (int x = 0; x < 214; x++) push_pix(x, y);
        issue(RASTER_CMD_FILL, 50, 60, 70, 80, 5);
        run_expect("fill", 5, 500);

        push_pix(220, 10);
        issue(RASTER_CMD_POINT, 220, 10, 0, 0, 2);
        run_expect("clip_point", 2, -1);

        for (int x = 200; x <= 230; x++) push_pix(x, 150);
        issue(RASTER_CMD_LINE, 200, 150, 230, 150, 4);
        run_expect("clip_line", 4, -1);

        issue(RASTER_CMD_FILL, 0, 0, 0, 0, 7);
        for (int i = 0; i < 1000; i++) @(negedge clk);
        check("midfill busy", int'(bus.gpu_busy), 1);
        check("midfill fb_x", int'(bus.fb_x), 1000 % 214);
        check("midfill fb_y", int'(bus.fb_y), 1000 / 214);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid busy", int'(bus.gpu_busy), 0);
        check("rst_mid write_en", int'(bus.fb_write_en), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst busy", int'(bus.gpu_busy), 0);
        check("post_rst write_en", int'(bus.fb_write_en), 0);

        push_pix(5, 7);
        issue(RASTER_CMD_POINT, 5, 7, 0, 0, 1);
        run_expect("point_after_reset", 1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/gpu_raster.md
# gpu_raster

Command-execution end of the CPU–GPU interface. Accepts one raster command at a time (FILL, POINT, LINE, RECT) from the CPU's `gpu_*` outputs and answers with `gpu_busy`. Expands each command into a stream of single-pixel framebuffer writes, one per clock. Sits between `vgacpu` and the framebuffer memory that the VGA scan-out reads.

## Interface

- `FB_WIDTH`, default 214, is the visible framebuffer width in pixels.
- `FB_HEIGHT`, default 160, is the visible framebuffer height in pixels.
- `clk` input, 1 bit: 50 MHz, the only clock.
- `rst_n` input, 1 bit: reset is synchronous and active-low.
- `gpu_command` input, `raster_command_t`: command opcode.
- `gpu_x0`, `gpu_y0`, `gpu_x1`, `gpu_y1` inputs, 8 bits each: coordinates.
- `gpu_colour` input, 3 bits: pixel colour.
- `gpu_execute_request` input, 1 bit: one-cycle start pulse.
- `gpu_busy` output, 1 bit: high while a command is executing.
- `fb_x` output, 8 bits: pixel x.
- `fb_y` output, 8 bits: pixel y.
- `fb_colour` output, 3 bits: pixel colour.
- `fb_write_en` output, 1 bit: write strobe. The framebuffer writes `fb_colour` at (`fb_x`, `fb_y`) when this is high.

## Operation

- **States:** IDLE, POINT, LINE, RECT, FILL.
  - `gpu_busy` = (state != IDLE). It is a registered-state decode.
- **IDLE:** on `gpu_execute_request`=1, the block latches command, coordinates and colour, then enters the state for the opcode.
  - A request while not IDLE is ignored. The CPU contract forbids it, but the block must stay unaffected.
- **POINT:** emits pixel (x0,y0), then returns to IDLE.
- **RECT:** filled rectangle, inclusive.
  - Corners are normalised at latch: xmin/xmax = min/max(x0,x1), likewise for y.
  - Raster order is row by row from ymin, and x from xmin to xmax within each row.
  - Count = (xmax−xmin+1)·(ymax−ymin+1).
- **FILL:** every pixel, y 0..FB_HEIGHT−1, x 0..FB_WIDTH−1 in raster order, with colour `gpu_colour`. Coordinates are ignored.
- **LINE:** integer Bresenham from (x0,y0) to (x1,y1), both endpoints inclusive.
  - Count = max(|dx|,|dy|)+1.
  - dx = |x1−x0|, dy = −|y1−y0|, sx/sy = ±1, err = dx+dy.
  - Each step: e2 = 2·err.
    - If e2 ≥ dy: err += dy, x += sx.
    - If e2 ≤ dx: err += dx, y += sy.
  - err and e2 are 11-bit signed. No overflow is possible for 8-bit coordinates.
  - After the pixel equal to (x1,y1) is emitted, the block returns to IDLE.
  - A degenerate line (x0=x1, y0=y1) emits one pixel.
- **Clipping:** a pixel with x ≥ FB_WIDTH or y ≥ FB_HEIGHT still consumes its cycle, but `fb_write_en`=0 for it. Iteration order and count are unchanged.
- **Reset values:** all outputs are 0 and state is IDLE.

## Timing

- **Cycle 0:** the edge at which the request is sampled. `gpu_busy` is still 0 during cycle 0.
- **Cycle 1:** `gpu_busy`=1, and the first pixel is valid on `fb_*`. Exactly one pixel is presented per cycle after that.
- **Busy duration:** `gpu_busy` stays high for exactly N cycles, where N = pixel count. It is low in cycle N+1.
- A new request may be issued in the first cycle `gpu_busy` reads 0.
- **Framebuffer writes:** `fb_x`, `fb_y`, `fb_colour` and `fb_write_en` are registered outputs. `fb_write_en` is low in every cycle without a valid in-range pixel.
- **Reset mid-operation:** at the edge where `rst_n`=0 is sampled, state becomes IDLE. `gpu_busy`=0 and `fb_write_en`=0 from the next cycle. No further pixels are emitted.
- **Wrap-around:** the RECT/FILL x counter resets to the row start on the row-end pixel, and y increments in the same cycle. On the last pixel the block goes to IDLE; counters do not wrap past it.
- **FILL length:** 34240 cycles at default parameters.

## Structure

- `raster_command_t` and its values (`RASTER_CMD_FILL`, `RASTER_CMD_POINT`, `RASTER_CMD_LINE`, `RASTER_CMD_RECT`) stay in package `common`.
- The state enum `raster_state_t` and the framebuffer dimension defaults go in a `gpu_common` package.
- **Sub-module `line_stepper`:** Bresenham datapath.
  - Inputs: load, step, endpoints.
  - Outputs: current x/y and done.
  - The top level owns the FSM, the RECT/FILL counters and the output registers.

## Test plan

- **POINT:** (100,100), colour 6 → single write at x=100, y=100, colour 6 in cycle 1; `gpu_busy` high for exactly 1 cycle.
- **LINE:** (10,10)→(100,100), colour 6 → 91 writes along the diagonal (i,i) for i=10..100; busy for 91 cycles.
  - Repeat reversed (100,100)→(10,10): same pixel set, descending order.
- **RECT with swapped corners:** (204,130)→(10,90), colour 3 → 195×41 = 7995 writes in raster order from (10,90) to (204,130); busy for 7995 cycles.
- **FILL:** colour 5 → 34240 writes covering (0,0)…(213,159), then `gpu_busy` falls. A second request pulsed mid-FILL changes nothing.
- **Clipping:** POINT (220,10) → busy for 1 cycle, `fb_write_en` never high.
  - LINE (200,150)→(230,150) → 31 cycles busy, with writes only for x=200..213.
- **Reset mid-FILL:** assert `rst_n`=0 at pixel 1000 → next cycle `gpu_busy`=0 and `fb_write_en`=0.
  - A subsequent POINT executes normally.
